// File: rtl/dsp_waddr_range_dispatcher.sv
// Write-address dispatcher: decodes AWADDR to a slave, forwards AW via a one-entry stage, keeps W/B issue order.
// Latency: AW accepted in cycle N drives sa_AW*_o in cycle N+1; its order entry is visible in cycle N+1.
// Backpressure: m_AWREADY_o low while the order FIFO is full or the stage holds an AW its slave has not taken.
module dsp_waddr_range_dispatcher #(
    parameter int SLV_AMT           = 4,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 8,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter logic [SLV_AMT*ADDR_WIDTH-1:0] SLV_BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [SLV_AMT*ADDR_WIDTH-1:0] SLV_MASK = {4{32'hFFFF_F000}},
    parameter int SLV_ID_W          = $clog2(SLV_AMT),
    parameter int CNT_W             = $clog2(OUTSTANDING_AMT + 1)
) (
    input  logic                         ACLK_i,
    input  logic                         ARESET_i,
    input  logic [TRANS_MST_ID_W-1:0]    m_AWID_i,
    input  logic [ADDR_WIDTH-1:0]        m_AWADDR_i,
    input  logic [TRANS_BURST_W-1:0]     m_AWBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]  m_AWLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0] m_AWSIZE_i,
    input  logic                         m_AWVALID_i,
    output logic                         m_AWREADY_o,
    input  logic                         m_WVALID_i,
    input  logic                         m_WREADY_i,
    output logic [TRANS_MST_ID_W-1:0]    sa_AWID_o,
    output logic [ADDR_WIDTH-1:0]        sa_AWADDR_o,
    output logic [TRANS_BURST_W-1:0]     sa_AWBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]  sa_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0] sa_AWSIZE_o,
    output logic [SLV_AMT-1:0]           sa_AWVALID_o,
    input  logic [SLV_AMT-1:0]           sa_AWREADY_i,
    output logic [SLV_ID_W-1:0]          dsp_WDATA_slv_id_o,
    output logic                         dsp_WDATA_decerr_o,
    output logic                         dsp_WDATA_last_o,
    output logic                         dsp_WDATA_disable_o,
    output logic [SLV_ID_W-1:0]          dsp_WRESP_slv_id_o,
    output logic                         dsp_WRESP_decerr_o,
    output logic                         dsp_WRESP_shift_en_o,
    output logic [CNT_W-1:0]             outst_cnt_o,
    output logic                         proto_err_o
);
    localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;

    typedef enum logic {ST_EMPTY, ST_FULL} stg_state_t;

    stg_state_t                   r_stg_state;
    stg_state_t                   w_stg_state_nxt;
    logic [SLV_ID_W-1:0]          r_stg_sel;
    logic [TRANS_MST_ID_W-1:0]    r_stg_id;
    logic [ADDR_WIDTH-1:0]        r_stg_addr;
    logic [TRANS_BURST_W-1:0]     r_stg_burst;
    logic [TRANS_DATA_LEN_W-1:0]  r_stg_len;
    logic [TRANS_DATA_SIZE_W-1:0] r_stg_size;

    logic [SLV_ID_W-1:0]          r_fifo_slv [OUTSTANDING_AMT];
    logic                         r_fifo_dec [OUTSTANDING_AMT];
    logic [TRANS_DATA_LEN_W-1:0]  r_fifo_len [OUTSTANDING_AMT];
    logic [PTR_W-1:0]             r_wptr;
    logic [PTR_W-1:0]             r_rptr;
    logic [CNT_W-1:0]             r_cnt;
    logic [TRANS_DATA_LEN_W-1:0]  r_beat;
    logic                         r_proto;

    logic [SLV_ID_W-1:0]          w_dec_sel;
    logic                         w_dec_hit;
    logic                         w_decerr;
    logic                         w_stg_hs;
    logic                         w_aw_rdy;
    logic                         w_aw_acc;
    logic                         w_stg_load;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic                         w_w_hs;
    logic                         w_last;
    logic                         w_push;
    logic                         w_pop;
    logic [SLV_ID_W-1:0]          w_head_slv;
    logic                         w_head_dec;
    logic [TRANS_DATA_LEN_W-1:0]  w_head_len;

    // Address decode: scan from the top so the lowest matching slave index wins.
    always_comb begin
        w_dec_sel = '0;
        w_dec_hit = 1'b0;
        for (int i = SLV_AMT - 1; i >= 0; i--) begin
            if ((m_AWADDR_i & SLV_MASK[ADDR_WIDTH*i +: ADDR_WIDTH]) == SLV_BASE[ADDR_WIDTH*i +: ADDR_WIDTH]) begin
                w_dec_sel = SLV_ID_W'(i);
                w_dec_hit = 1'b1;
            end
        end
    end

    assign w_decerr     = ~w_dec_hit;
    assign w_fifo_full  = (r_cnt == CNT_W'(OUTSTANDING_AMT));
    assign w_fifo_empty = (r_cnt == '0);
    assign w_stg_hs     = (r_stg_state == ST_FULL) & sa_AWREADY_i[r_stg_sel];
    // Ready never looks at AWVALID: a free (or freeing) stage and a FIFO slot are enough for any request.
    assign w_aw_rdy     = ~w_fifo_full & ((r_stg_state == ST_EMPTY) | w_stg_hs);
    assign m_AWREADY_o  = w_aw_rdy;
    assign w_aw_acc     = m_AWVALID_i & w_aw_rdy;
    // Decode-error AWs are accepted and ordered but never occupy the stage.
    assign w_stg_load   = w_aw_acc & ~w_decerr;

    assign w_head_slv   = r_fifo_slv[r_rptr];
    assign w_head_dec   = r_fifo_dec[r_rptr];
    assign w_head_len   = r_fifo_len[r_rptr];
    // W beats arriving while no order entry exists are not counted against any burst.
    assign w_w_hs       = m_WVALID_i & m_WREADY_i;
    assign w_last       = ~w_fifo_empty & (r_beat == w_head_len);
    assign w_push       = w_aw_acc;
    assign w_pop        = w_w_hs & w_last;

    // Stage next state: a load wins over a plain handshake so back-to-back AWs see no bubble.
    always_comb begin
        w_stg_state_nxt = r_stg_state;
        case (r_stg_state)
            ST_EMPTY: if (w_stg_load) w_stg_state_nxt = ST_FULL;
            ST_FULL: begin
                if (w_stg_load)    w_stg_state_nxt = ST_FULL;
                else if (w_stg_hs) w_stg_state_nxt = ST_EMPTY;
            end
            default:  w_stg_state_nxt = ST_EMPTY;
        endcase
    end

    // Stage register: capture decoded AW payload on a forwarding accept, hold it until the slave takes it.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_stg_state <= ST_EMPTY;
            r_stg_sel   <= '0;
            r_stg_id    <= '0;
            r_stg_addr  <= '0;
            r_stg_burst <= '0;
            r_stg_len   <= '0;
            r_stg_size  <= '0;
        end else begin
            r_stg_state <= w_stg_state_nxt;
            if (w_stg_load) begin
                r_stg_sel   <= w_dec_sel;
                r_stg_id    <= m_AWID_i;
                r_stg_addr  <= m_AWADDR_i;
                r_stg_burst <= m_AWBURST_i;
                r_stg_len   <= m_AWLEN_i;
                r_stg_size  <= m_AWSIZE_i;
            end
        end
    end

    // One-hot valid toward the slave selected for the staged AW.
    always_comb begin
        sa_AWVALID_o = '0;
        if (r_stg_state == ST_FULL) sa_AWVALID_o[r_stg_sel] = 1'b1;
    end

    assign sa_AWID_o    = r_stg_id;
    assign sa_AWADDR_o  = r_stg_addr;
    assign sa_AWBURST_o = r_stg_burst;
    assign sa_AWLEN_o   = r_stg_len;
    assign sa_AWSIZE_o  = r_stg_size;

    // Order FIFO storage: entries are written at AW accept time; pointers alone define validity.
    always_ff @(posedge ACLK_i) begin
        if (w_push) begin
            r_fifo_slv[r_wptr] <= w_dec_sel;
            r_fifo_dec[r_wptr] <= w_decerr;
            r_fifo_len[r_wptr] <= m_AWLEN_i;
        end
    end

    // Order FIFO pointers, occupancy, beat counter and sticky protocol error.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_proto <= 1'b0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_w_hs & ~w_fifo_empty) r_beat <= w_last ? '0 : r_beat + 1'b1;
            if (w_w_hs & w_fifo_empty)  r_proto <= 1'b1;
        end
    end

    assign dsp_WDATA_slv_id_o   = w_fifo_empty ? '0 : w_head_slv;
    assign dsp_WDATA_decerr_o   = ~w_fifo_empty & w_head_dec;
    assign dsp_WDATA_last_o     = w_last;
    assign dsp_WDATA_disable_o  = w_fifo_empty;
    assign dsp_WRESP_slv_id_o   = w_pop ? w_head_slv : '0;
    assign dsp_WRESP_decerr_o   = w_pop & w_head_dec;
    assign dsp_WRESP_shift_en_o = w_pop;
    assign outst_cnt_o          = r_cnt;
    assign proto_err_o          = r_proto;
endmodule

// File: tb/tb_dsp_waddr_range_dispatcher.sv
// Bench for dsp_waddr_range_dispatcher: directed scenarios then randomized traffic.
// Expected AW forwards and W-order entries are queued at accept time; a monitor pops them on DUT outputs.
// Inputs change on the falling edge; the monitor samples 2 time units later.
module tb_dsp_waddr_range_dispatcher;
    localparam int SLV_AMT = 4;
    localparam int OUT_AMT = 8;
    localparam logic [127:0] BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [127:0] MASK = {4{32'hFFFF_F000}};

    logic        clk = 1'b0;
    logic        ARESET_i;
    logic [4:0]  m_AWID_i;
    logic [31:0] m_AWADDR_i;
    logic [1:0]  m_AWBURST_i;
    logic [7:0]  m_AWLEN_i;
    logic [2:0]  m_AWSIZE_i;
    logic        m_AWVALID_i, m_AWREADY_o, m_WVALID_i, m_WREADY_i;
    logic [4:0]  sa_AWID_o;
    logic [31:0] sa_AWADDR_o;
    logic [1:0]  sa_AWBURST_o;
    logic [7:0]  sa_AWLEN_o;
    logic [2:0]  sa_AWSIZE_o;
    logic [3:0]  sa_AWVALID_o, sa_AWREADY_i;
    logic [1:0]  dsp_WDATA_slv_id_o, dsp_WRESP_slv_id_o;
    logic        dsp_WDATA_decerr_o, dsp_WDATA_last_o, dsp_WDATA_disable_o;
    logic        dsp_WRESP_decerr_o, dsp_WRESP_shift_en_o, proto_err_o;
    logic [3:0]  outst_cnt_o;

    dsp_waddr_range_dispatcher #(
        .SLV_AMT(SLV_AMT), .OUTSTANDING_AMT(OUT_AMT), .ADDR_WIDTH(32), .TRANS_MST_ID_W(5),
        .TRANS_BURST_W(2), .TRANS_DATA_LEN_W(8), .TRANS_DATA_SIZE_W(3),
        .SLV_BASE(BASE), .SLV_MASK(MASK)
    ) dut (
        .ACLK_i(clk), .ARESET_i(ARESET_i),
        .m_AWID_i(m_AWID_i), .m_AWADDR_i(m_AWADDR_i), .m_AWBURST_i(m_AWBURST_i),
        .m_AWLEN_i(m_AWLEN_i), .m_AWSIZE_i(m_AWSIZE_i), .m_AWVALID_i(m_AWVALID_i),
        .m_AWREADY_o(m_AWREADY_o), .m_WVALID_i(m_WVALID_i), .m_WREADY_i(m_WREADY_i),
        .sa_AWID_o(sa_AWID_o), .sa_AWADDR_o(sa_AWADDR_o), .sa_AWBURST_o(sa_AWBURST_o),
        .sa_AWLEN_o(sa_AWLEN_o), .sa_AWSIZE_o(sa_AWSIZE_o), .sa_AWVALID_o(sa_AWVALID_o),
        .sa_AWREADY_i(sa_AWREADY_i),
        .dsp_WDATA_slv_id_o(dsp_WDATA_slv_id_o), .dsp_WDATA_decerr_o(dsp_WDATA_decerr_o),
        .dsp_WDATA_last_o(dsp_WDATA_last_o), .dsp_WDATA_disable_o(dsp_WDATA_disable_o),
        .dsp_WRESP_slv_id_o(dsp_WRESP_slv_id_o), .dsp_WRESP_decerr_o(dsp_WRESP_decerr_o),
        .dsp_WRESP_shift_en_o(dsp_WRESP_shift_en_o), .outst_cnt_o(outst_cnt_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  slv;
        bit          dec;
        logic [4:0]  id;
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [7:0]  len;
        logic [2:0]  size;
    } aw_t;

    aw_t awq[$];   // accepted, decodable AWs not yet taken by their slave
    aw_t ordq[$];  // accepted AWs whose W burst has not completed
    int  beat_m;
    bit  proto_m;
    int  total = 0;
    int  bad = 0;

    logic        nx_rst, nx_awv, nx_wv, nx_wr;
    logic [31:0] nx_addr;
    logic [7:0]  nx_len;
    logic [3:0]  nx_sardy;
    bit          acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Address map: four 4 KiB windows starting at 0; anything at or above 0x4000 is unmapped.
    function automatic void decode(input logic [31:0] a, output logic [1:0] s, output bit d);
        if (a < 32'h4000) begin
            s = 2'(a >> 12);
            d = 1'b0;
        end else begin
            s = 2'd0;
            d = 1'b1;
        end
    endfunction

    task automatic set_idle();
        nx_rst = 1'b0; nx_awv = 1'b0; nx_addr = '0; nx_len = '0;
        nx_sardy = 4'hF; nx_wv = 1'b0; nx_wr = 1'b0;
    endtask

    // One clock: drive on the falling edge, then record any AW accept into the expectation queues.
    task automatic cyc();
        aw_t e;
        @(negedge clk);
        ARESET_i     = nx_rst;
        m_AWVALID_i  = nx_awv;
        m_AWADDR_i   = nx_addr;
        m_AWLEN_i    = nx_len;
        m_AWID_i     = 5'($urandom);
        m_AWBURST_i  = 2'($urandom);
        m_AWSIZE_i   = 3'($urandom);
        sa_AWREADY_i = nx_sardy;
        m_WVALID_i   = nx_wv;
        m_WREADY_i   = nx_wr;
        #3;
        acc = !ARESET_i && m_AWVALID_i && m_AWREADY_o;
        if (acc) begin
            decode(m_AWADDR_i, e.slv, e.dec);
            e.id = m_AWID_i; e.addr = m_AWADDR_i; e.burst = m_AWBURST_i;
            e.len = m_AWLEN_i; e.size = m_AWSIZE_i;
            if (!e.dec) awq.push_back(e);
            ordq.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        set_idle();
        while ((ordq.size() != 0 || awq.size() != 0) && n < 3000) begin
            nx_wv = (ordq.size() != 0);
            nx_wr = nx_wv;
            cyc();
            n++;
        end
        chk("drain_done", 64'(ordq.size() + awq.size()), 64'd0);
    endtask

    // Monitor: compare every output against the queued expectations, then advance the model.
    bit         mon_full, mon_hs, mon_rdy, mon_last, mon_whs;
    logic [3:0] mon_vld;
    initial begin
        beat_m  = 0;
        proto_m = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (ARESET_i) begin
                awq.delete();
                ordq.delete();
                beat_m  = 0;
                proto_m = 1'b0;
            end else begin
                mon_full = (ordq.size() == OUT_AMT);
                mon_hs   = (awq.size() != 0) && sa_AWREADY_i[awq[0].slv];
                mon_rdy  = !mon_full && (awq.size() == 0 || mon_hs);
                mon_vld  = (awq.size() != 0) ? 4'(1 << awq[0].slv) : 4'd0;
                mon_last = (ordq.size() != 0) && (beat_m == int'(ordq[0].len));
                mon_whs  = m_WVALID_i && m_WREADY_i;
                chk("aw_ready", 64'(m_AWREADY_o), 64'(mon_rdy));
                chk("sa_valid", 64'(sa_AWVALID_o), 64'(mon_vld));
                if (awq.size() != 0)
                    chk("sa_payload", 64'({sa_AWID_o, sa_AWADDR_o, sa_AWBURST_o, sa_AWLEN_o, sa_AWSIZE_o}),
                        64'({awq[0].id, awq[0].addr, awq[0].burst, awq[0].len, awq[0].size}));
                chk("outst_cnt", 64'(outst_cnt_o), 64'(ordq.size()));
                chk("wdata_disable", 64'(dsp_WDATA_disable_o), 64'(ordq.size() == 0));
                chk("wdata_last", 64'(dsp_WDATA_last_o), 64'(mon_last));
                if (ordq.size() != 0)
                    chk("wdata_head", 64'({dsp_WDATA_slv_id_o, dsp_WDATA_decerr_o}),
                        64'({ordq[0].slv, ordq[0].dec}));
                chk("proto_err", 64'(proto_err_o), 64'(proto_m));
                chk("wresp_shift", 64'(dsp_WRESP_shift_en_o), 64'(mon_whs && mon_last));
                if (dsp_WRESP_shift_en_o && ordq.size() != 0)
                    chk("wresp_entry", 64'({dsp_WRESP_slv_id_o, dsp_WRESP_decerr_o}),
                        64'({ordq[0].slv, ordq[0].dec}));
                if (mon_hs) void'(awq.pop_front());
                if (mon_whs) begin
                    if (ordq.size() == 0) proto_m = 1'b1;
                    else if (mon_last) begin
                        void'(ordq.pop_front());
                        beat_m = 0;
                    end else beat_m++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d", total);
        $fatal(1, "watchdog");
    end

    int k, n, r;
    initial begin
        ARESET_i = 1'b1; m_AWVALID_i = 1'b0; m_AWADDR_i = '0; m_AWLEN_i = '0;
        m_AWID_i = '0; m_AWBURST_i = '0; m_AWSIZE_i = '0; sa_AWREADY_i = '0;
        m_WVALID_i = 1'b0; m_WREADY_i = 1'b0;
        set_idle(); nx_rst = 1'b1;
        repeat (3) cyc();
        nx_rst = 1'b0; cyc();
        chk("rst_outst", 64'(outst_cnt_o), 64'd0);
        chk("rst_disable", 64'(dsp_WDATA_disable_o), 64'd1);
        chk("rst_sa_valid", 64'(sa_AWVALID_o), 64'd0);
        chk("rst_proto", 64'(proto_err_o), 64'd0);
        chk("rst_shift", 64'(dsp_WRESP_shift_en_o), 64'd0);

        // Single mapped burst to slave 1, four beats.
        nx_awv = 1'b1; nx_addr = 32'h1004; nx_len = 8'd3; cyc();
        chk("t1_accept", 64'(acc), 64'd1);
        set_idle(); cyc();
        chk("t1_sa_valid", 64'(sa_AWVALID_o), 64'b0010);
        nx_wv = 1'b1; nx_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_last", 64'(dsp_WDATA_last_o), 64'(i == 3));
        end
        chk("t1_shift", 64'(dsp_WRESP_shift_en_o), 64'd1);
        chk("t1_wresp_slv", 64'(dsp_WRESP_slv_id_o), 64'd1);
        set_idle(); cyc();
        chk("t1_outst", 64'(outst_cnt_o), 64'd0);

        // Unmapped address: accepted, never forwarded, DECERR on both sides.
        nx_awv = 1'b1; nx_addr = 32'h8000; nx_len = 8'd1; cyc();
        chk("t2_accept", 64'(acc), 64'd1);
        set_idle(); cyc();
        chk("t2_no_fwd", 64'(sa_AWVALID_o), 64'd0);
        chk("t2_wd_decerr", 64'(dsp_WDATA_decerr_o), 64'd1);
        nx_wv = 1'b1; nx_wr = 1'b1; cyc();
        chk("t2_shift_b1", 64'(dsp_WRESP_shift_en_o), 64'd0);
        cyc();
        chk("t2_shift_b2", 64'(dsp_WRESP_shift_en_o), 64'd1);
        chk("t2_wresp_decerr", 64'(dsp_WRESP_decerr_o), 64'd1);
        set_idle(); cyc();

        // Fill the order FIFO, stall the stage, then retire one burst.
        k = 0; nx_awv = 1'b1; nx_len = 8'd0;
        for (int i = 0; i < 20 && k < 8; i++) begin
            nx_addr = 32'h2000 | ($urandom & 32'hFFF);
            cyc();
            if (acc) k++;
        end
        chk("t3_accepts", 64'(k), 64'd8);
        nx_sardy = 4'h0; cyc();
        chk("t3_rdy_full", 64'(m_AWREADY_o), 64'd0);
        chk("t3_outst8", 64'(outst_cnt_o), 64'd8);
        nx_wv = 1'b1; nx_wr = 1'b1; nx_sardy = 4'hF; cyc();
        chk("t3_rdy_retire", 64'(m_AWREADY_o), 64'd0);
        nx_wv = 1'b0; nx_wr = 1'b0; cyc();
        chk("t3_rdy_back", 64'(m_AWREADY_o), 64'd1);
        drain();

        // Back-to-back accepts with every slave ready.
        set_idle(); nx_awv = 1'b1; k = 0;
        for (int i = 0; i < 4; i++) begin
            nx_addr = 32'(i) << 12;
            cyc();
            if (acc) k++;
        end
        chk("t4_b2b", 64'(k), 64'd4);
        drain();

        // W handshake with nothing outstanding.
        set_idle(); nx_wv = 1'b1; nx_wr = 1'b1; cyc();
        set_idle(); cyc();
        chk("t5_proto", 64'(proto_err_o), 64'd1);
        chk("t5_outst", 64'(outst_cnt_o), 64'd0);
        cyc();
        chk("t5_proto_sticky", 64'(proto_err_o), 64'd1);

        // Reset mid-burst with three entries queued and an AW stuck in the stage.
        set_idle(); nx_sardy = 4'b0111; nx_awv = 1'b1; nx_len = 8'd7;
        nx_addr = 32'h0010; cyc();
        nx_addr = 32'h1010; cyc();
        nx_addr = 32'h3010; cyc();
        nx_awv = 1'b0; nx_wv = 1'b1; nx_wr = 1'b1; cyc(); cyc();
        chk("t6_outst3", 64'(outst_cnt_o), 64'd3);
        set_idle(); nx_sardy = 4'b0111; nx_rst = 1'b1; cyc();
        nx_rst = 1'b0; cyc();
        chk("t6_outst", 64'(outst_cnt_o), 64'd0);
        chk("t6_disable", 64'(dsp_WDATA_disable_o), 64'd1);
        chk("t6_sa_valid", 64'(sa_AWVALID_o), 64'd0);
        chk("t6_proto", 64'(proto_err_o), 64'd0);

        // Longest burst: AWLEN=255 needs 256 beats.
        set_idle(); nx_awv = 1'b1; nx_addr = 32'h3ABC; nx_len = 8'hFF; cyc();
        set_idle(); nx_wv = 1'b1; nx_wr = 1'b1; n = 0;
        do begin
            cyc();
            n++;
        end while (!dsp_WRESP_shift_en_o && n < 300);
        chk("t7_beats", 64'(n), 64'd256);
        drain();

        // Randomized traffic.
        set_idle(); nx_rst = 1'b1; cyc();
        for (int i = 0; i < 1500; i++) begin
            r        = $urandom_range(0, 4);
            nx_rst   = 1'b0;
            nx_awv   = ($urandom_range(0, 2) != 0);
            nx_addr  = (r < 4) ? ((32'(r) << 12) | ($urandom & 32'hFFF)) : (32'h4000 | $urandom);
            nx_len   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            nx_sardy = 4'($urandom);
            nx_wv    = 1'($urandom_range(0, 1));
            nx_wr    = (ordq.size() != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
            cyc();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
